// File: rtl/pcap_stream_arbiter.sv
// pcap_stream_arbiter
// Packet-level round-robin arbiter that merges NUM_PORTS packet sources
// (pcap replay instances) onto one AXIS_WIDTH-bit output bus. Grants move
// only on packet boundaries, so packets never interleave.
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   port_enable           per-port arbitration enable (looked at only in ARB)
//   s_data/s_strb         packed per-port beat payload / byte enables
//   s_valid/s_sop/s_eop   per-port beat qualifiers
//   s_ready               per-port accept (combinational)
//   data/strb/valid/sop/eop  registered output beat
//   ready                 downstream accept
//   grant                 currently granted port
//   busy                  high while a packet is being transferred (XFER)
//   pktcount              packets handed downstream (eop handshakes), wraps
//   framing_err           sticky per-port sop/eop framing error flags
//
// Handshake: a beat moves across an interface in any cycle where valid and
// ready are both high; valid never depends on ready, and the output beat is
// held unchanged while valid && !ready.
module pcap_stream_arbiter #(
  parameter int NUM_PORTS  = 2,
  parameter int AXIS_WIDTH = 64
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_PORTS-1:0]              port_enable,
  input  logic [NUM_PORTS*AXIS_WIDTH-1:0]   s_data,
  input  logic [NUM_PORTS*AXIS_WIDTH/8-1:0] s_strb,
  input  logic [NUM_PORTS-1:0]              s_valid,
  input  logic [NUM_PORTS-1:0]              s_sop,
  input  logic [NUM_PORTS-1:0]              s_eop,
  output logic [NUM_PORTS-1:0]              s_ready,
  output logic [AXIS_WIDTH-1:0]             data,
  output logic [AXIS_WIDTH/8-1:0]           strb,
  output logic                              valid,
  output logic                              sop,
  output logic                              eop,
  input  logic                              ready,
  output logic [$clog2(NUM_PORTS)-1:0]      grant,
  output logic                              busy,
  output logic [15:0]                       pktcount,
  output logic [NUM_PORTS-1:0]              framing_err
);

  localparam int GW = $clog2(NUM_PORTS);
  localparam int SW = AXIS_WIDTH / 8;

  typedef enum logic [0:0] {ST_ARB, ST_XFER} state_t;

  state_t                 state_q, state_d;
  logic [GW-1:0]          grant_q, grant_d;
  logic [GW-1:0]          last_q, last_d;
  logic                   first_q, first_d;
  logic [AXIS_WIDTH-1:0]  data_q, data_d;
  logic [SW-1:0]          strb_q, strb_d;
  logic                   valid_q, valid_d;
  logic                   sop_q, sop_d;
  logic                   eop_q, eop_d;
  logic [15:0]            cnt_q, cnt_d;
  logic [NUM_PORTS-1:0]   ferr_q, ferr_d;

  logic [NUM_PORTS-1:0]   cand;
  logic                   found;
  logic [GW-1:0]          pick;
  int                     arb_idx;

  logic                   out_free;
  logic                   accept;
  logic [AXIS_WIDTH-1:0]  g_data;
  logic [SW-1:0]          g_strb;
  logic                   g_valid, g_sop, g_eop;

  assign cand     = s_valid & port_enable;
  assign out_free = ~valid_q | ready;
  assign g_data   = s_data[int'(grant_q)*AXIS_WIDTH +: AXIS_WIDTH];
  assign g_strb   = s_strb[int'(grant_q)*SW +: SW];
  assign g_valid  = s_valid[grant_q];
  assign g_sop    = s_sop[grant_q];
  assign g_eop    = s_eop[grant_q];

  // Round-robin search: first candidate at or after last_grant+1, wrapping.
  always_comb begin
    found   = 1'b0;
    pick    = grant_q;
    arb_idx = 0;
    for (int k = 1; k <= NUM_PORTS; k++) begin
      arb_idx = (int'(last_q) + k) % NUM_PORTS;
      if (!found && cand[arb_idx]) begin
        found = 1'b1;
        pick  = GW'(arb_idx);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    first_d = first_q;
    data_d  = data_q;
    strb_d  = strb_q;
    sop_d   = sop_q;
    eop_d   = eop_q;
    ferr_d  = ferr_q;
    s_ready = '0;
    accept  = 1'b0;

    case (state_q)
      ST_ARB: begin
        if (found) begin
          state_d = ST_XFER;
          grant_d = pick;
          first_d = 1'b1;
        end
      end
      ST_XFER: begin
        s_ready[grant_q] = out_free;
        accept = g_valid & out_free;
        if (accept) begin
          data_d  = g_data;
          strb_d  = g_strb;
          sop_d   = g_sop;
          eop_d   = g_eop;
          first_d = 1'b0;
          // sop must be set on exactly the first beat after a grant.
          if (first_q != g_sop) ferr_d[grant_q] = 1'b1;
          if (g_eop) begin
            state_d = ST_ARB;
            last_d  = grant_q;
          end
        end
      end
      default: state_d = ST_ARB;
    endcase

    if (accept)                valid_d = 1'b1;
    else if (valid_q && ready) valid_d = 1'b0;
    else                       valid_d = valid_q;

    cnt_d = cnt_q;
    if (valid_q && ready && eop_q) cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_ARB;
      grant_q <= '0;
      last_q  <= GW'(NUM_PORTS - 1);
      first_q <= 1'b0;
      data_q  <= '0;
      strb_q  <= '0;
      valid_q <= 1'b0;
      sop_q   <= 1'b0;
      eop_q   <= 1'b0;
      cnt_q   <= '0;
      ferr_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      first_q <= first_d;
      data_q  <= data_d;
      strb_q  <= strb_d;
      valid_q <= valid_d;
      sop_q   <= sop_d;
      eop_q   <= eop_d;
      cnt_q   <= cnt_d;
      ferr_q  <= ferr_d;
    end
  end

  assign data        = data_q;
  assign strb        = strb_q;
  assign valid       = valid_q;
  assign sop         = sop_q;
  assign eop         = eop_q;
  assign grant       = grant_q;
  assign busy        = (state_q == ST_XFER);
  assign pktcount    = cnt_q;
  assign framing_err = ferr_q;

endmodule

// File: tb/tb_pcap_stream_arbiter.sv
// Directed testbench for pcap_stream_arbiter (3 ports, 64-bit data).
// Inputs are driven on the falling edge; outputs are compared 1 time unit
// later, so registered outputs show the state left by the previous rising
// edge and s_ready reflects the inputs of the current cycle.
module tb_pcap_stream_arbiter;

  localparam int NP = 3;
  localparam int W  = 64;

  logic            clk = 1'b0;
  logic            rst;
  logic [NP-1:0]   port_enable;
  logic [NP*W-1:0] s_data;
  logic [NP*8-1:0] s_strb;
  logic [NP-1:0]   s_valid, s_sop, s_eop, s_ready;
  logic [W-1:0]    data;
  logic [7:0]      strb;
  logic            valid, sop, eop, ready;
  logic [1:0]      grant;
  logic            busy;
  logic [15:0]     pktcount;
  logic [NP-1:0]   framing_err;

  int checks = 0;
  int errors = 0;

  pcap_stream_arbiter #(.NUM_PORTS(NP), .AXIS_WIDTH(W)) dut (
    .clk(clk), .rst(rst), .port_enable(port_enable),
    .s_data(s_data), .s_strb(s_strb), .s_valid(s_valid),
    .s_sop(s_sop), .s_eop(s_eop), .s_ready(s_ready),
    .data(data), .strb(strb), .valid(valid), .sop(sop), .eop(eop),
    .ready(ready), .grant(grant), .busy(busy), .pktcount(pktcount),
    .framing_err(framing_err)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  typedef struct {
    logic          rst;
    logic [2:0]    en, sv, ss, se;
    logic          rdy;
    logic [7:0]    d, st;
    logic [2:0]    x_srdy;
    logic          x_v, x_sop, x_eop;
    logic [63:0]   x_data;
    logic [7:0]    x_strb;
    logic [1:0]    x_g;
    logic          x_busy;
    logic [15:0]   x_cnt;
    logic [2:0]    x_ferr;
  } vec_t;

  vec_t vq[$];

  // Beat payload seen on port p: port number in the top byte, tag in the low byte.
  function automatic logic [63:0] mk(input int p, input logic [7:0] d);
    logic [7:0] pb;
    pb = 8'(p);
    return {pb, 48'h0, d};
  endfunction

  function automatic vec_t V(
    input logic r, input logic [2:0] en, sv, ss, se, input logic rdy,
    input logic [7:0] d, st, input logic [2:0] xr, input logic xv, xs, xe,
    input logic [63:0] xd, input logic [7:0] xst, input logic [1:0] xg,
    input logic xb, input logic [15:0] xc, input logic [2:0] xf);
    vec_t v;
    v.rst = r; v.en = en; v.sv = sv; v.ss = ss; v.se = se; v.rdy = rdy;
    v.d = d; v.st = st; v.x_srdy = xr; v.x_v = xv; v.x_sop = xs;
    v.x_eop = xe; v.x_data = xd; v.x_strb = xst; v.x_g = xg;
    v.x_busy = xb; v.x_cnt = xc; v.x_ferr = xf;
    return v;
  endfunction

  // Driver: one cycle of inputs, every port carrying mk(port, d) / st.
  task automatic drv(input logic r, input logic [2:0] en, sv, ss, se,
                     input logic rd, input logic [7:0] d,
                     input logic [7:0] st = 8'hFF);
    @(negedge clk);
    rst = r; port_enable = en; s_valid = sv; s_sop = ss; s_eop = se;
    ready = rd;
    for (int i = 0; i < NP; i++) begin
      s_data[i*W +: W] = mk(i, d);
      s_strb[i*8 +: 8] = st;
    end
    #1;
  endtask

  task automatic chk(input string name, input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    logic [99:0] act_v, exp_v;
    rst = 1'b1; port_enable = '0; s_valid = '0; s_sop = '0; s_eop = '0;
    s_data = '0; s_strb = '0; ready = 1'b0;

    // Reset, 3-beat packet from port 0, then reset and 3-way round robin
    vq.push_back(V(1,7,0,0,0,1,8'h00,8'hFF, 0,0,0,0,64'h0,8'h00,0,0,0,0));
    vq.push_back(V(0,7,1,1,0,1,8'h01,8'hFF, 0,0,0,0,64'h0,8'h00,0,0,0,0));
    vq.push_back(V(0,7,1,1,0,1,8'h01,8'hFF, 1,0,0,0,64'h0,8'h00,0,1,0,0));
    vq.push_back(V(0,7,1,0,0,1,8'h02,8'hFF, 1,1,1,0,mk(0,8'h01),8'hFF,0,1,0,0));
    vq.push_back(V(0,7,1,0,1,1,8'h03,8'h0F, 1,1,0,0,mk(0,8'h02),8'hFF,0,1,0,0));
    vq.push_back(V(0,7,0,0,0,1,8'h00,8'hFF, 0,1,0,1,mk(0,8'h03),8'h0F,0,0,0,0));
    vq.push_back(V(0,7,0,0,0,1,8'h00,8'hFF, 0,0,0,1,mk(0,8'h03),8'h0F,0,0,1,0));
    vq.push_back(V(1,7,0,0,0,1,8'h00,8'hFF, 0,0,0,1,mk(0,8'h03),8'h0F,0,0,1,0));
    vq.push_back(V(0,7,7,7,0,1,8'h10,8'hFF, 0,0,0,0,64'h0,8'h00,0,0,0,0));
    vq.push_back(V(0,7,7,7,0,1,8'h10,8'hFF, 1,0,0,0,64'h0,8'h00,0,1,0,0));
    vq.push_back(V(0,7,7,0,7,1,8'h11,8'hFF, 1,1,1,0,mk(0,8'h10),8'hFF,0,1,0,0));
    vq.push_back(V(0,7,7,7,0,1,8'h20,8'hFF, 0,1,0,1,mk(0,8'h11),8'hFF,0,0,0,0));
    vq.push_back(V(0,7,7,7,0,1,8'h20,8'hFF, 2,0,0,1,mk(0,8'h11),8'hFF,1,1,1,0));
    vq.push_back(V(0,7,7,0,7,1,8'h21,8'hFF, 2,1,1,0,mk(1,8'h20),8'hFF,1,1,1,0));
    vq.push_back(V(0,7,7,7,0,1,8'h30,8'hFF, 0,1,0,1,mk(1,8'h21),8'hFF,1,0,1,0));
    vq.push_back(V(0,7,7,7,0,1,8'h30,8'hFF, 4,0,0,1,mk(1,8'h21),8'hFF,2,1,2,0));
    vq.push_back(V(0,7,7,0,7,1,8'h31,8'hFF, 4,1,1,0,mk(2,8'h30),8'hFF,2,1,2,0));
    vq.push_back(V(0,7,7,7,0,1,8'h40,8'hFF, 0,1,0,1,mk(2,8'h31),8'hFF,2,0,2,0));
    vq.push_back(V(0,7,7,7,0,1,8'h40,8'hFF, 1,0,0,1,mk(2,8'h31),8'hFF,0,1,3,0));
    vq.push_back(V(0,7,7,0,7,1,8'h41,8'hFF, 1,1,1,0,mk(0,8'h40),8'hFF,0,1,3,0));
    vq.push_back(V(0,7,7,7,0,1,8'h50,8'hFF, 0,1,0,1,mk(0,8'h41),8'hFF,0,0,3,0));
    vq.push_back(V(0,7,7,7,0,1,8'h50,8'hFF, 2,0,0,1,mk(0,8'h41),8'hFF,1,1,4,0));
    vq.push_back(V(0,7,7,0,7,1,8'h51,8'hFF, 2,1,1,0,mk(1,8'h50),8'hFF,1,1,4,0));
    vq.push_back(V(0,7,7,7,0,1,8'h60,8'hFF, 0,1,0,1,mk(1,8'h51),8'hFF,1,0,4,0));
    vq.push_back(V(0,7,7,7,0,1,8'h60,8'hFF, 4,0,0,1,mk(1,8'h51),8'hFF,2,1,5,0));
    vq.push_back(V(0,7,7,0,7,1,8'h61,8'hFF, 4,1,1,0,mk(2,8'h60),8'hFF,2,1,5,0));
    vq.push_back(V(0,7,0,0,0,1,8'h00,8'hFF, 0,1,0,1,mk(2,8'h61),8'hFF,2,0,5,0));
    vq.push_back(V(0,7,0,0,0,1,8'h00,8'hFF, 0,0,0,1,mk(2,8'h61),8'hFF,2,0,6,0));

    drv(1, 0, 0, 0, 0, 0, 8'h00);
    drv(1, 0, 0, 0, 0, 0, 8'h00);

    foreach (vq[i]) begin
      drv(vq[i].rst, vq[i].en, vq[i].sv, vq[i].ss, vq[i].se, vq[i].rdy,
          vq[i].d, vq[i].st);
      act_v = {s_ready, valid, sop, eop, data, strb, grant, busy, pktcount,
               framing_err};
      exp_v = {vq[i].x_srdy, vq[i].x_v, vq[i].x_sop, vq[i].x_eop,
               vq[i].x_data, vq[i].x_strb, vq[i].x_g, vq[i].x_busy,
               vq[i].x_cnt, vq[i].x_ferr};
      checks++;
      if (act_v !== exp_v) begin
        errors++;
        $display("FAIL row%0d: got %h expected %h", i, act_v, exp_v);
      end
    end

    // Backpressure: ready 1,0,0,1 during a 4-beat packet from port 0
    drv(1, 7, 0, 0, 0, 1, 8'h00);
    drv(0, 7, 3'b001, 3'b001, 0, 1, 8'hA0); chk("bp_arb", busy, 0);
    drv(0, 7, 3'b001, 3'b001, 0, 1, 8'hA0); chk("bp_srdy_a", s_ready, 3'b001);
    drv(0, 7, 3'b001, 0, 0, 1, 8'hA1);
    chk("bp_beat0", {valid, sop, eop, data}, {3'b110, mk(0, 8'hA0)});
    chk("bp_srdy_b", s_ready, 3'b001);
    drv(0, 7, 3'b001, 0, 0, 0, 8'hA2);
    chk("bp_stall_srdy0", s_ready, 0);
    chk("bp_beat1", {valid, sop, eop, data}, {3'b100, mk(0, 8'hA1)});
    drv(0, 7, 3'b001, 0, 0, 0, 8'hA2);
    chk("bp_stall_srdy1", s_ready, 0);
    chk("bp_hold", {valid, sop, eop, data}, {3'b100, mk(0, 8'hA1)});
    drv(0, 7, 3'b001, 0, 0, 1, 8'hA2);
    chk("bp_hold_rel", {valid, sop, eop, data}, {3'b100, mk(0, 8'hA1)});
    chk("bp_srdy_c", s_ready, 3'b001);
    drv(0, 7, 3'b001, 0, 3'b001, 1, 8'hA3);
    chk("bp_beat2", {valid, sop, eop, data}, {3'b100, mk(0, 8'hA2)});
    drv(0, 7, 0, 0, 0, 1, 8'h00);
    chk("bp_beat3", {valid, sop, eop, data}, {3'b101, mk(0, 8'hA3)});
    chk("bp_back_arb", busy, 0);
    drv(0, 7, 0, 0, 0, 1, 8'h00);
    chk("bp_valid_clr", valid, 0);
    chk("bp_cnt", pktcount, 1);

    // Enable masking: only port 1 enabled, then cleared mid-packet
    drv(1, 7, 0, 0, 0, 1, 8'h00);
    drv(0, 3'b010, 3'b011, 3'b011, 0, 1, 8'hB0); chk("en_arb", busy, 0);
    drv(0, 3'b010, 3'b011, 3'b011, 0, 1, 8'hB0);
    chk("en_grant1", {grant, busy, s_ready}, {2'd1, 1'b1, 3'b010});
    drv(0, 3'b000, 3'b011, 0, 0, 1, 8'hB1);
    chk("en_mid_keep", {busy, s_ready}, {1'b1, 3'b010});
    drv(0, 3'b000, 3'b011, 0, 3'b011, 1, 8'hB2);
    chk("en_mid_eop", s_ready, 3'b010);
    drv(0, 3'b000, 3'b011, 3'b011, 0, 1, 8'hC0); chk("en_none_a", busy, 0);
    drv(0, 3'b000, 3'b011, 3'b011, 0, 1, 8'hC0);
    chk("en_none_b", {grant, busy, s_ready}, {2'd1, 1'b0, 3'b000});
    drv(0, 3'b001, 3'b011, 3'b011, 3'b011, 1, 8'hC0); chk("en_p0_arb", busy, 0);
    drv(0, 3'b001, 3'b011, 3'b011, 3'b011, 1, 8'hC0);
    chk("en_grant0", {grant, busy, s_ready}, {2'd0, 1'b1, 3'b001});
    drv(0, 3'b001, 0, 0, 0, 1, 8'h00);
    chk("en_single", {valid, sop, eop, data}, {3'b111, mk(0, 8'hC0)});
    chk("en_single_arb", busy, 0);
    drv(0, 3'b001, 0, 0, 0, 1, 8'h00);
    chk("en_cnt", pktcount, 2);
    chk("en_ferr", framing_err, 0);

    // Framing: missing sop on port 1, extra sop on port 2
    drv(0, 7, 3'b010, 0, 0, 1, 8'hE0);
    drv(0, 7, 3'b010, 0, 0, 1, 8'hE0);
    chk("fe_grant1", {grant, s_ready}, {2'd1, 3'b010});
    chk("fe_pre", framing_err, 0);
    drv(0, 7, 3'b010, 0, 3'b010, 1, 8'hE1);
    chk("fe_nosop", framing_err, 3'b010);
    chk("fe_fwd", {valid, sop, eop, data}, {3'b100, mk(1, 8'hE0)});
    drv(0, 7, 3'b100, 3'b100, 0, 1, 8'hF0); chk("fe_arb", busy, 0);
    drv(0, 7, 3'b100, 3'b100, 0, 1, 8'hF0);
    chk("fe_grant2", {grant, s_ready}, {2'd2, 3'b100});
    drv(0, 7, 3'b100, 3'b100, 3'b100, 1, 8'hF1);
    chk("fe_first_ok", framing_err, 3'b010);
    drv(0, 7, 0, 0, 0, 1, 8'h00);
    chk("fe_extra_sop", framing_err, 3'b110);
    chk("fe_fwd2", {valid, sop, eop, data}, {3'b111, mk(2, 8'hF1)});
    for (int k = 0; k < 3; k++) begin
      drv(0, 7, 0, 0, 0, 1, 8'h00);
      chk("fe_sticky", framing_err, 3'b110);
    end

    // Reset in the middle of a port 1 packet after port 0 was served last
    drv(0, 7, 3'b001, 3'b001, 3'b001, 1, 8'h80);
    drv(0, 7, 3'b001, 3'b001, 3'b001, 1, 8'h80);
    chk("rs_grant0", {grant, s_ready}, {2'd0, 3'b001});
    drv(0, 7, 3'b010, 3'b010, 0, 1, 8'h90); chk("rs_arb", busy, 0);
    drv(0, 7, 3'b010, 3'b010, 0, 1, 8'h90);
    chk("rs_grant1", {grant, s_ready}, {2'd1, 3'b010});
    drv(0, 7, 3'b010, 0, 0, 1, 8'h91);
    chk("rs_beat0", {valid, sop, eop, data}, {3'b110, mk(1, 8'h90)});
    drv(1, 7, 3'b010, 0, 0, 1, 8'h92);
    chk("rs_beat1", {valid, sop, eop, data, busy},
        {3'b100, mk(1, 8'h91), 1'b1});
    drv(0, 7, 3'b011, 3'b011, 0, 1, 8'hA5);
    chk("rs_state", {valid, busy, s_ready, grant, pktcount, framing_err},
        {1'b0, 1'b0, 3'b000, 2'd0, 16'd0, 3'b000});
    drv(0, 7, 3'b011, 3'b011, 0, 1, 8'hA5);
    chk("rs_next_p0", {grant, busy, s_ready}, {2'd0, 1'b1, 3'b001});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pcap_stream_arbiter.md
# pcap_stream_arbiter

Packet-level round-robin arbiter that merges up to NUM_PORTS AXI-stream-style packet sources (pcap replay instances) onto one shared AXIS_WIDTH-bit output bus. Grants change only on packet boundaries, so packets are never interleaved. It sits between several pcap replay sources and the single device-under-test ingress port of a network test bench. It also reports per-arbiter packet counts and per-port framing errors.

## Interface
- NUM_PORTS, 2, number of source ports (2..8)
- AXIS_WIDTH, 64, data width in bits (multiple of 8)
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- port_enable  in  NUM_PORTS  per-port arbitration enable; sampled only in ARB
- s_data  in  NUM_PORTS*AXIS_WIDTH  port i at [i*AXIS_WIDTH +: AXIS_WIDTH]
- s_strb  in  NUM_PORTS*AXIS_WIDTH/8  byte enables, port i at [i*AXIS_WIDTH/8 +: AXIS_WIDTH/8]
- s_valid, s_sop, s_eop  in  NUM_PORTS  per-port beat qualifiers
- s_ready  out  NUM_PORTS  per-port accept (combinational)
- data  out  AXIS_WIDTH  output beat data (registered)
- strb  out  AXIS_WIDTH/8  output byte enables (registered)
- valid, sop, eop  out  1  output qualifiers (registered)
- ready  in  1  downstream accept
- grant  out  clog2(NUM_PORTS)  currently granted port
- busy  out  1  high in state XFER
- pktcount  out  16  packets forwarded (eop beats accepted downstream), wraps
- framing_err  out  NUM_PORTS  sticky per-port error flags

## Operation
- States: ARB, XFER.
- ARB: candidates are ports i with s_valid[i] && port_enable[i].
  - Search starts at (last_grant+1) mod NUM_PORTS and wraps; the first candidate is granted.
  - With a candidate: latch it into grant and go to XFER next cycle.
  - With none: stay in ARB, grant unchanged.
- XFER: s_ready[g] = (~valid || ready) for the granted port g. All other s_ready are 0. s_ready is 0 in ARB.
- Beat accept: when s_valid[g] && s_ready[g], the output register loads data, strb, sop and eop from port g, and valid is set.
  - If valid && ready with no new load, valid clears.
- Packet end: an accepted input beat with s_eop[g]=1 sets last_grant <= g and returns to ARB on the next cycle.
- Framing errors, each setting framing_err[g]:
  - First accepted beat after a grant has s_sop=0: the beat is still forwarded.
  - A non-first accepted beat has s_sop=1: the beat is still forwarded.
  - framing_err clears only on rst.
- pktcount increments on each output handshake (valid && ready && eop), modulo 2^16.
- port_enable changes during XFER do not abort the current packet. They affect only the next ARB decision.
- A granted port that drops s_valid mid-packet is simply waited on. There is no timeout and no grant change.
- The output register is held stable (data, strb, sop, eop, valid) while valid && ~ready.

## Timing
- Reset values:
  - state=ARB; last_grant=NUM_PORTS-1, so port 0 has first priority.
  - grant=0, busy=0, valid=0, sop=0, eop=0, data=0, strb=0, pktcount=0, framing_err=0.
  - s_ready=0 during and after reset until the first XFER.
- Arbitration latency: candidate present in ARB at cycle t -> busy=1 and s_ready[g] possible at t+1.
- Data latency: input beat accepted at cycle t -> appears on data/valid at t+1.
- Packet turnaround: eop accepted at t -> ARB at t+1 -> next grant XFER at t+2. This is exactly one idle input cycle between packets.
- Throughput: one beat per cycle while ready=1 and the granted s_valid=1.
- Backpressure: with ready=0 and valid=1, s_ready[g]=0 in the same cycle. No beat is lost or duplicated.
- A single-beat packet (sop and eop on the same beat) is legal. It passes through XFER for exactly one accepted beat.
- Simultaneous events:
  - eop accepted while ARB candidates exist: the decision is made in the following ARB cycle, not before.
  - Output handshake with eop in the same cycle as a new input load: pktcount increments and the register reloads.
- rst asserted mid-packet: the next cycle is in the reset state. The partially sent packet is truncated; downstream sees valid=0.

## Test plan
- Reset, then port 0 sends a 3-beat packet with ready=1 -> busy at cycle 1, data beats out at cycles 2-4 with sop on the first and eop on the third; strb=0xFF, 0xFF, 0x0F; pktcount=1.
- Ports 0, 1 and 2 all hold valid continuously with 2-beat packets -> grant order 0,1,2,0,1,2; no interleaving; 1-cycle gap between packets; pktcount=6 after six packets.
- ready toggles 1,0,0,1 during a 4-beat packet -> output register held on ready=0 cycles; all 4 beats delivered exactly once, in order.
- port_enable=0b10 with ports 0 and 1 both valid -> only port 1 is granted. Clearing port_enable[1] mid-packet still completes that packet; port 0 is granted afterwards only once port_enable[0]=1.
- Port 1's first beat has s_sop=0 -> beat forwarded, framing_err=0b10, and the flag stays set until rst.
- rst pulse on beat 2 of a 5-beat packet -> valid=0, pktcount=0, and the next grant goes to port 0 first.
